// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S audio output path.
// Used by i2s_clkgen and i2s_tx.
package audio_pkg;

  localparam int SAMPLE_W_DEF  = 16;
  localparam int BCLK_HALF_DEF = 4;
  localparam int SYNC_CYCLES   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_e;

  // One frame carries a left and a right slot of sample_w bits each.
  function automatic int frame_bclks(input int sample_w);
    return 2 * sample_w;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// BCLK/LRCLK generation for the I2S transmitter.
// Also emits strobes on BCLK falling edges, at slot starts and at frame starts.
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int BCLK_HALF = BCLK_HALF_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  input  logic enable,
  output logic bclk,
  output logic lrclk,
  output logic fall_stb,
  output logic slot_stb,
  output logic frame_stb
);

  localparam int FRAME_BCLKS = frame_bclks(SAMPLE_W);
  localparam int DIV_W       = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int BIT_W       = $clog2(FRAME_BCLKS);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BCLKS - 1);
  localparam logic [BIT_W-1:0] SLOT_FIRST = BIT_W'(SAMPLE_W);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q    <= 1'b1;
      lrclk_q   <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
    end
  end

  // While armed, bit_cnt sits on the last bit so the first falling edge wraps to a new frame.
  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    bclk_d    = bclk_q;
    lrclk_d   = lrclk_q;
    fall_stb  = 1'b0;
    slot_stb  = 1'b0;
    frame_stb = 1'b0;
    if (arm) begin
      div_cnt_d = '0;
      bit_cnt_d = BIT_LAST;
      bclk_d    = 1'b1;
      lrclk_d   = 1'b1;
    end else if (!enable) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      bclk_d    = 1'b1;
      lrclk_d   = 1'b1;
    end else begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        bclk_d    = ~bclk_q;
        if (bclk_q) begin
          fall_stb  = 1'b1;
          bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
          frame_stb = (bit_cnt_d == '0);
          slot_stb  = (bit_cnt_d == '0) || (bit_cnt_d == SLOT_FIRST);
        end
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
      lrclk_d = bit_cnt_d[BIT_W-1];
    end
  end

  assign bclk  = bclk_q;
  assign lrclk = lrclk_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: serialises each mono PCM sample into both slots of a frame.
// Optional macro I2S_VOLUME_EN adds a 3-bit Vol port (arithmetic right shift of the sample).
module i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int BCLK_HALF = BCLK_HALF_DEF
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                INIT_FINISH,
  input  logic [SAMPLE_W-1:0] Data_in,
  output logic                BCLK,
  output logic                LRCLK,
  output logic                DACDAT,
  output logic                data_over
`ifdef I2S_VOLUME_EN
  ,
  input  logic [2:0]          Vol
`endif
);

  localparam int SYNC_W = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_CYCLES - 1);

  state_e              state_q, state_d;
  logic [SYNC_W-1:0]   sync_cnt_q, sync_cnt_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [SAMPLE_W-1:0] sr_q, sr_d;
  logic                dacdat_q, dacdat_d;
  logic                data_over_q, data_over_d;
  logic [SAMPLE_W-1:0] scaled;
  logic                arm, run_en;
  logic                fall_stb, slot_stb, frame_stb;

  // Gated by INIT_FINISH so a drop returns everything to idle on the very next edge.
  assign arm    = (state_q == SYNC) && INIT_FINISH;
  assign run_en = (state_q == RUN)  && INIT_FINISH;

  i2s_clkgen #(
    .SAMPLE_W  (SAMPLE_W),
    .BCLK_HALF (BCLK_HALF)
  ) u_clkgen (
    .clk       (Clk),
    .rst_n     (Reset),
    .arm       (arm),
    .enable    (run_en),
    .bclk      (BCLK),
    .lrclk     (LRCLK),
    .fall_stb  (fall_stb),
    .slot_stb  (slot_stb),
    .frame_stb (frame_stb)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      sync_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    if (!INIT_FINISH) begin
      state_d    = IDLE;
      sync_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = SYNC;
          sync_cnt_d = '0;
        end
        SYNC: begin
          if (sync_cnt_q == SYNC_LAST) begin
            state_d    = RUN;
            sync_cnt_d = '0;
          end else begin
            sync_cnt_d = sync_cnt_q + SYNC_W'(1);
          end
        end
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef I2S_VOLUME_EN
  always_comb begin
    scaled = $unsigned($signed(Data_in) >>> Vol);
  end
`else
  always_comb begin
    scaled = Data_in;
  end
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sample_q    <= '0;
      sr_q        <= '0;
      dacdat_q    <= 1'b0;
      data_over_q <= 1'b0;
    end else begin
      sample_q    <= sample_d;
      sr_q        <= sr_d;
      dacdat_q    <= dacdat_d;
      data_over_q <= data_over_d;
    end
  end

  // The bit leaving sr_q at a slot start is bit 0 of the previous slot: this gives the I2S one-BCLK delay.
  always_comb begin
    sample_d    = sample_q;
    sr_d        = sr_q;
    dacdat_d    = dacdat_q;
    data_over_d = 1'b0;
    if (!run_en) begin
      sample_d = '0;
      sr_d     = '0;
      dacdat_d = 1'b0;
    end else if (fall_stb) begin
      dacdat_d = sr_q[SAMPLE_W-1];
      if (frame_stb) begin
        sample_d    = scaled;
        sr_d        = scaled;
        data_over_d = 1'b1;
      end else if (slot_stb) begin
        sr_d = sample_q;
      end else begin
        sr_d = {sr_q[SAMPLE_W-2:0], 1'b0};
      end
    end
  end

  assign DACDAT    = dacdat_q;
  assign data_over = data_over_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed self-checking bench for i2s_tx with a codec-side I2S receiver model.
// Build with I2S_VOLUME_EN defined to also exercise the Vol port.
module tb_i2s_tx;

  localparam int SAMPLE_W  = 16;
  localparam int BCLK_HALF = 2;
  localparam int FRAME_CLK = 2 * BCLK_HALF * 2 * SAMPLE_W;

  logic                Clk = 1'b0;
  logic                Reset = 1'b1;
  logic                INIT_FINISH = 1'b0;
  logic [SAMPLE_W-1:0] Data_in = '0;
  logic                BCLK, LRCLK, DACDAT, data_over;
`ifdef I2S_VOLUME_EN
  logic [2:0]          vol_in = 3'd0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  i2s_tx #(
    .SAMPLE_W  (SAMPLE_W),
    .BCLK_HALF (BCLK_HALF)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .INIT_FINISH (INIT_FINISH),
    .Data_in     (Data_in),
    .BCLK        (BCLK),
    .LRCLK       (LRCLK),
    .DACDAT      (DACDAT),
    .data_over   (data_over)
`ifdef I2S_VOLUME_EN
    ,
    .Vol         (vol_in)
`endif
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  // Codec receiver: samples on BCLK rising edges, a slot word completes at the next LRCLK change.
  logic                dec_clr = 1'b0;
  logic [SAMPLE_W-1:0] rx_sr;
  int                  rx_cnt;
  logic                lr_prev;
  logic [SAMPLE_W-1:0] lq[$];
  logic [SAMPLE_W-1:0] rq[$];

  always @(posedge BCLK or posedge dec_clr) begin
    if (dec_clr) begin
      rx_cnt  = 0;
      rx_sr   = '0;
      lr_prev = 1'b1;
      lq.delete();
      rq.delete();
    end else if (LRCLK != lr_prev) begin
      if (rx_cnt == SAMPLE_W - 1) begin
        if (lr_prev) rq.push_back({rx_sr[SAMPLE_W-2:0], DACDAT});
        else         lq.push_back({rx_sr[SAMPLE_W-2:0], DACDAT});
      end
      rx_cnt  = 0;
      rx_sr   = '0;
      lr_prev = LRCLK;
    end else begin
      rx_sr  = {rx_sr[SAMPLE_W-2:0], DACDAT};
      rx_cnt = rx_cnt + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic init, input logic [SAMPLE_W-1:0] data);
    @(negedge Clk);
    INIT_FINISH = init;
    Data_in     = data;
  endtask

  task automatic clearDecoder();
    dec_clr = 1'b1;
    #1;
    dec_clr = 1'b0;
  endtask

  task automatic waitDataOver(input string tag, output int cyc);
    bit found = 1'b0;
    cyc = 0;
    for (int i = 0; i < 3 * FRAME_CLK && !found; i++) begin
      @(posedge Clk);
      #1;
      if (data_over) begin
        found = 1'b1;
        cyc   = cyc_cnt;
      end
    end
    checkOutput(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic waitRight(input string tag, input int n);
    int i = 0;
    while (rq.size() < n && i < (n + 2) * FRAME_CLK) begin
      @(posedge Clk);
      i++;
    end
    #1;
    checkOutput(tag, rq.size() >= n, 32'd1);
  endtask

  // Edge 1 enters SYNC, edge 3 enters RUN, edge 5 is the first falling BCLK edge.
  task automatic checkStartup(input string tag);
    for (int k = 1; k <= 7; k++) begin
      @(posedge Clk);
      #1;
      checkOutput($sformatf("%s_dover_k%0d", tag, k), {31'd0, data_over}, {31'd0, k == 5});
      if (k == 5) begin
        checkOutput({tag, "_lrclk_first"}, {31'd0, LRCLK}, 32'd0);
        checkOutput({tag, "_bclk_first"},  {31'd0, BCLK},  32'd0);
      end
    end
  endtask

  task automatic checkIdleHold(input string tag, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (BCLK !== 1'b1 || LRCLK !== 1'b1 || DACDAT !== 1'b0 || data_over !== 1'b0) bad++;
    end
    checkOutput(tag, bad, 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_bclk"},   {31'd0, BCLK},      32'd1);
    checkOutput({tag, "_lrclk"},  {31'd0, LRCLK},     32'd1);
    checkOutput({tag, "_dacdat"}, {31'd0, DACDAT},    32'd0);
    checkOutput({tag, "_dover"},  {31'd0, data_over}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c0, c1, c2, c3;

    // Power-on reset and idle hold
    #1 Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checkResetOutputs("por");
    @(negedge Clk);
    Reset = 1'b1;
    checkIdleHold("idle_after_por", 100);

    // Startup and first frame with A5C3
    clearDecoder();
    applyStimulus(1'b1, 16'hA5C3);
    checkStartup("start");
    waitRight("start_frame_done", 1);
    checkOutput("start_left",  {16'd0, lq[0]}, 32'h0000A5C3);
    checkOutput("start_right", {16'd0, rq[0]}, 32'h0000A5C3);

    // Stepped samples on successive frames
    waitDataOver("step_p0", c0);
    clearDecoder();
    applyStimulus(1'b1, 16'h0001);
    waitDataOver("step_p1", c1);
    checkOutput("step_period1", c1 - c0, FRAME_CLK);
    applyStimulus(1'b1, 16'h8000);
    waitDataOver("step_p2", c2);
    checkOutput("step_period2", c2 - c1, FRAME_CLK);
    applyStimulus(1'b1, 16'h7FFF);
    waitDataOver("step_p3", c3);
    checkOutput("step_period3", c3 - c2, FRAME_CLK);
    waitRight("step_frames_done", 4);
    checkOutput("step_l0", {16'd0, lq[0]}, 32'h0000A5C3);
    checkOutput("step_r0", {16'd0, rq[0]}, 32'h0000A5C3);
    checkOutput("step_l1", {16'd0, lq[1]}, 32'h00000001);
    checkOutput("step_r1", {16'd0, rq[1]}, 32'h00000001);
    checkOutput("step_l2", {16'd0, lq[2]}, 32'h00008000);
    checkOutput("step_r2", {16'd0, rq[2]}, 32'h00008000);
    checkOutput("step_l3", {16'd0, lq[3]}, 32'h00007FFF);
    checkOutput("step_r3", {16'd0, rq[3]}, 32'h00007FFF);

    // Data_in toggled mid-frame must not disturb the latched sample
    waitDataOver("mid_pa", c0);
    clearDecoder();
    applyStimulus(1'b1, 16'h1357);
    waitDataOver("mid_pb", c1);
    repeat (20) @(posedge Clk);
    applyStimulus(1'b1, 16'hFFFF);
    repeat (40) @(posedge Clk);
    applyStimulus(1'b1, 16'h0000);
    repeat (40) @(posedge Clk);
    applyStimulus(1'b1, 16'h2468);
    waitRight("mid_frames_done", 2);
    checkOutput("mid_left",  {16'd0, lq[1]}, 32'h00001357);
    checkOutput("mid_right", {16'd0, rq[1]}, 32'h00001357);

`ifdef I2S_VOLUME_EN
    // Volume: arithmetic shift sampled at frame start
    waitDataOver("vol_pa", c0);
    clearDecoder();
    @(negedge Clk);
    vol_in  = 3'd3;
    Data_in = 16'h8000;
    waitDataOver("vol_pb", c1);
    @(negedge Clk);
    vol_in  = 3'd0;
    Data_in = 16'h1234;
    waitDataOver("vol_pc", c2);
    waitRight("vol_frames_done", 3);
    checkOutput("vol3_left",  {16'd0, lq[1]}, 32'h0000F000);
    checkOutput("vol3_right", {16'd0, rq[1]}, 32'h0000F000);
    checkOutput("vol0_left",  {16'd0, lq[2]}, 32'h00001234);
    checkOutput("vol0_right", {16'd0, rq[2]}, 32'h00001234);
`endif

    // INIT_FINISH dropped while bit 7 of the left slot is on DACDAT
    waitDataOver("drop_pa", c0);
    applyStimulus(1'b1, 16'h0080);
    waitDataOver("drop_pb", c1);
    repeat (9 * 2 * BCLK_HALF) @(posedge Clk);
    #1;
    checkOutput("drop_bit7_dacdat", {31'd0, DACDAT}, 32'd1);
    checkOutput("drop_bit7_lrclk",  {31'd0, LRCLK},  32'd0);
    applyStimulus(1'b0, 16'h0080);
    @(posedge Clk);
    #1;
    checkResetOutputs("drop_next");
    checkIdleHold("drop_idle", 10);
    clearDecoder();
    applyStimulus(1'b1, 16'hC001);
    checkStartup("restart");
    waitRight("restart_frame_done", 1);
    checkOutput("restart_left",  {16'd0, lq[0]}, 32'h0000C001);
    checkOutput("restart_right", {16'd0, rq[0]}, 32'h0000C001);

    // Asynchronous reset in the middle of a slot
    waitDataOver("rst_pa", c0);
    repeat (2 * BCLK_HALF) @(posedge Clk);
    #1;
    checkOutput("pre_rst_dacdat", {31'd0, DACDAT}, 32'd1);
    checkOutput("pre_rst_bclk",   {31'd0, BCLK},   32'd0);
    #1;
    Reset       = 1'b0;
    INIT_FINISH = 1'b0;
    #1;
    checkResetOutputs("async_rst");
    @(negedge Clk);
    Reset = 1'b1;
    checkIdleHold("idle_after_rst", 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
